logic_unit_seq: RTL and testbench
=================================

Name: logic_unit_seq

Overview:
Parametrised, registered successor to the basic two-input gate set. Applies one of eight bitwise logic operations to WIDTH-bit operands under a valid/ready handshake, with one output register stage. Adds an accumulator that can stand in for operand A, a zero flag and a saturating operation counter. Sits between an operand source and a result consumer in the NandGame datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, 16, width of the accepted-operation counter (>=1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
op  in  3  operation select, sampled with the beat
a  in  WIDTH  operand A
b  in  WIDTH  operand B
use_acc  in  1  1: accumulator replaces a as operand A
clr_acc  in  1  single-cycle accumulator clear
out_valid  out  1  result register holds an undelivered result
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
zero  out  1  registered: result == 0
acc  out  WIDTH  accumulator value
op_count  out  CNT_W  saturating count of accepted beats

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n). While rst_n=0: out_valid=0, result=0, zero=0, acc=0, op_count=0. Reset asserted mid-transfer discards the pending result; nothing is replayed.
- in_ready = !out_valid || out_ready (combinational). in_ready=1 while in reset/after reset.
- Accept: in_valid && in_ready at a rising edge. Deliver: out_valid && out_ready at a rising edge.
- Operand A = use_acc ? acc : a.
- op codes: 0 NAND ~(A&b); 1 INV ~A (b ignored); 2 AND; 3 OR; 4 XOR; 5 NOR; 6 XNOR; 7 PASS A. All bitwise over WIDTH; no illegal codes.
- Latency 1: on accept, result/zero load at that edge, out_valid=1 next cycle.
- Deliver without accept: out_valid->0; result/zero hold last value.
- Deliver and accept same edge: out_valid stays 1, new result loads; full throughput, no bubble.
- out_valid=1 && out_ready=0: result, zero, out_valid hold stable; in_ready=0; in_valid ignored.
- acc: on accept, acc <= computed result (whether or not use_acc). clr_acc=1 forces acc<=0 at that edge and has priority over the accept's acc write; the accepted beat still produces its result (computed with pre-clear acc if use_acc=1).
- op_count increments by 1 per accept; saturates at 2^CNT_W-1, never wraps. Cleared only by reset.
- in_valid dropped without accept is legal; no state change.

Test Plan:
- Reset: drive rst_n=0 mid-stream with out_valid=1 -> out_valid, result, acc, op_count all 0 immediately (before next edge); in_ready=1.
- Op sweep, WIDTH=8, a=0xF0, b=0x3C, out_ready=1, op 0..7 back-to-back -> results 0xCF,0x0F,0x30,0xFC,0xCC,0x03,0x33,0xF0 on consecutive cycles, one cycle after each accept, out_valid continuously 1.
- Backpressure: out_ready=0, send beats a=0xAA/op7 then a=0x55/op7 -> result 0xAA held, in_ready=0, second beat not accepted; raise out_ready -> 0xAA delivered, 0x55 accepted same edge and appears next cycle.
- Accumulator: clr_acc pulse, then use_acc=1, op=3 (OR), b=0x01,0x02,0x04 -> results 0x01,0x03,0x07, acc=0x07; then op=4 with b=0x07 and clr_acc=1 same cycle -> result 0x00, zero=1, acc=0x00.
- Counter saturation: CNT_W=4, 20 accepted beats -> op_count 15, stays 15.
- Zero flag: a=0x5A, b=0x5A, op=4 -> result 0x00, zero=1; next op=3 -> result 0x5A, zero=0.

Source files
------------

// File: rtl/logic_unit_seq.sv
// logic_unit_seq: registered eight-op bitwise logic unit with valid/ready handshake, accumulator, zero flag and saturating op counter
module logic_unit_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  input  logic             clr_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] res;
  logic             accept;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign opa      = use_acc ? acc : a;
  // select the bitwise operation on the effective operands
  always_comb begin
    res = op == 3'd0 ? ~(opa & b) :
          op == 3'd1 ? ~opa :
          op == 3'd2 ? opa & b :
          op == 3'd3 ? opa | b :
          op == 3'd4 ? opa ^ b :
          op == 3'd5 ? ~(opa | b) :
          op == 3'd6 ? ~(opa ^ b) : opa;
  end
  // output stage: load on accept, drain on delivery, hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= res;
      zero      <= res == '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
  // accumulator follows accepted results; clear wins over the write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else if (clr_acc) acc <= '0;
    else if (accept) acc <= res;
  end
  // accepted-beat counter that sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count <= '0;
    else if (accept && op_count != '1) op_count <= op_count + 1'b1;
  end
endmodule

// File: tb/tb_logic_unit_seq.sv
// tb_logic_unit_seq: directed and randomized checks of logic_unit_seq against a transaction-level model
module tb_logic_unit_seq;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       in_valid = 0, use_acc = 0, clr_acc = 0, out_ready = 0;
  logic [2:0] op = 0;
  logic [7:0] a = 0, b = 0;
  logic       in_ready, out_valid, zero;
  logic [7:0] result, acc;
  logic [3:0] op_count;
  int errors = 0, checks = 0;
  logic       m_valid, m_zero;
  logic [7:0] m_res, m_acc;
  int         m_cnt;

  logic_unit_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .use_acc(use_acc), .clr_acc(clr_acc), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .acc(acc), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gate(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      3'd0: return ~(x & y);
      3'd1: return ~x;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return ~(x | y);
      3'd6: return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_zero = 0; m_res = 0; m_acc = 0; m_cnt = 0;
  endtask

  task automatic tick();
    logic [7:0] r;
    logic       take;
    r = gate(op, use_acc ? m_acc : a, b);
    take = in_valid && (!m_valid || out_ready);
    @(posedge clk);
    if (take) begin
      m_res = r; m_zero = (r == 0); m_valid = 1;
      if (m_cnt < 15) m_cnt++;
    end else if (out_ready) m_valid = 0;
    if (clr_acc) m_acc = 0; else if (take) m_acc = r;
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1 || out_valid !== 0 || result !== 0 || zero !== 0 || acc !== 0 || op_count !== 0) begin
      errors++; $display("FAIL reset_initial: rdy=%b v=%b res=%h z=%b acc=%h cnt=%0d required 1 0 00 0 00 0", in_ready, out_valid, result, zero, acc, op_count);
    end
    @(negedge clk); rst_n = 1; model_reset();
    in_valid = 1; a = 8'h81; op = 3'd7; out_ready = 0; tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 1 || result !== 8'h81 || acc !== 8'h81 || op_count !== 1) begin
      errors++; $display("FAIL reset_setup: v=%b res=%h acc=%h cnt=%0d required 1 81 81 1", out_valid, result, acc, op_count);
    end
    #2 rst_n = 0; #1;
    checks++;
    if (in_ready !== 1 || out_valid !== 0 || result !== 0 || zero !== 0 || acc !== 0 || op_count !== 0) begin
      errors++; $display("FAIL reset_midstream: rdy=%b v=%b res=%h z=%b acc=%h cnt=%0d required 1 0 00 0 00 0", in_ready, out_valid, result, zero, acc, op_count);
    end
    model_reset();
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_op_sweep();
    logic [7:0] exp_tab [8] = '{8'hCF, 8'h0F, 8'h30, 8'hFC, 8'hCC, 8'h03, 8'h33, 8'hF0};
    a = 8'hF0; b = 8'h3C; out_ready = 1; use_acc = 0; in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      op = i[2:0]; tick();
      checks++;
      if (result !== exp_tab[i] || out_valid !== 1) begin
        errors++; $display("FAIL op_sweep[%0d]: res=%h v=%b required %h 1", i, result, out_valid, exp_tab[i]);
      end
    end
    in_valid = 0; tick();
  endtask

  task automatic test_backpressure();
    out_ready = 0; in_valid = 1; op = 3'd7; use_acc = 0; a = 8'hAA; tick();
    a = 8'h55; tick();
    checks++;
    if (result !== 8'hAA || out_valid !== 1 || in_ready !== 0) begin
      errors++; $display("FAIL backpressure_hold: res=%h v=%b rdy=%b required aa 1 0", result, out_valid, in_ready);
    end
    out_ready = 1; #1;
    checks++;
    if (in_ready !== 1) begin
      errors++; $display("FAIL backpressure_release_rdy: rdy=%b required 1", in_ready);
    end
    tick();
    in_valid = 0;
    checks++;
    if (result !== 8'h55 || out_valid !== 1) begin
      errors++; $display("FAIL backpressure_release: res=%h v=%b required 55 1", result, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 0 || result !== 8'h55) begin
      errors++; $display("FAIL backpressure_drain: v=%b res=%h required 0 55", out_valid, result);
    end
  endtask

  task automatic test_accumulator();
    logic [7:0] bs [3] = '{8'h01, 8'h02, 8'h04};
    logic [7:0] ex [3] = '{8'h01, 8'h03, 8'h07};
    out_ready = 1; in_valid = 0; clr_acc = 1; tick();
    clr_acc = 0; use_acc = 1; op = 3'd3; in_valid = 1; a = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      b = bs[i]; tick();
      checks++;
      if (result !== ex[i] || acc !== ex[i]) begin
        errors++; $display("FAIL acc_or[%0d]: res=%h acc=%h required %h %h", i, result, acc, ex[i], ex[i]);
      end
    end
    op = 3'd4; b = 8'h07; clr_acc = 1; tick();
    clr_acc = 0; in_valid = 0; use_acc = 0;
    checks++;
    if (result !== 8'h00 || zero !== 1 || acc !== 8'h00) begin
      errors++; $display("FAIL acc_clear_xor: res=%h z=%b acc=%h required 00 1 00", result, zero, acc);
    end
    in_valid = 1; use_acc = 1; op = 3'd7; tick();
    in_valid = 0; use_acc = 0;
    checks++;
    if (result !== 8'h00) begin
      errors++; $display("FAIL acc_after_clear: res=%h required 00", result);
    end
  endtask

  task automatic test_zero();
    out_ready = 1; in_valid = 1; use_acc = 0; a = 8'h5A; b = 8'h5A; op = 3'd4; tick();
    checks++;
    if (result !== 8'h00 || zero !== 1) begin
      errors++; $display("FAIL zero_set: res=%h z=%b required 00 1", result, zero);
    end
    op = 3'd3; tick();
    in_valid = 0;
    checks++;
    if (result !== 8'h5A || zero !== 0) begin
      errors++; $display("FAIL zero_clear: res=%h z=%b required 5a 0", result, zero);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk); rst_n = 0; #1; model_reset(); @(negedge clk); rst_n = 1;
    out_ready = 1; in_valid = 1; op = 3'd2;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom); b = 8'($urandom); tick();
      checks++;
      if (op_count !== 4'((i + 1 > 15) ? 15 : i + 1)) begin
        errors++; $display("FAIL saturation[%0d]: cnt=%0d required %0d", i, op_count, (i + 1 > 15) ? 15 : i + 1);
      end
    end
    in_valid = 0; tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom); out_ready = ($urandom_range(0, 3) != 0); op = 3'($urandom);
      a = 8'($urandom); b = 8'($urandom); use_acc = 1'($urandom); clr_acc = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (in_ready !== (!m_valid || out_ready)) begin
        errors++; $display("FAIL random_ready[%0d]: rdy=%b required %b", i, in_ready, !m_valid || out_ready);
      end
      tick();
      checks++;
      if (out_valid !== m_valid || result !== m_res || zero !== m_zero || acc !== m_acc || op_count !== 4'(m_cnt)) begin
        errors++; $display("FAIL random_state[%0d]: v=%b res=%h z=%b acc=%h cnt=%0d required %b %h %b %h %0d",
                           i, out_valid, result, zero, acc, op_count, m_valid, m_res, m_zero, m_acc, m_cnt);
      end
    end
    in_valid = 0; clr_acc = 0;
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_op_sweep();
    test_backpressure();
    test_accumulator();
    test_zero();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
